// File: rtl/field_mul_array.sv
`default_nettype none
// ============================================================================
//  Module   : field_mul_array
//  Purpose  : NLANES-lane prime-field multiplier. Each lane computes
//             c = a*b mod PRIME (mac=0) or c = c + a*b mod PRIME (mac=1)
//             using MSB-first bit-serial interleaved modular
//             multiplication. One bit of b is consumed per cycle and all
//             lanes share one control FSM.
//  Ports    : clk, rstb (async active-low)
//             en, mac, lane_mask : request and mode, sampled when ready=1
//             a, b               : packed operands, lane i at [i*NBITS +: NBITS]
//             ready              : idle / able to accept en
//             ready_pulse        : one-cycle strobe, c has just updated
//             c                  : packed registered results (reset to 1)
//             err                : sticky dropped-request flag, present only
//                                  when FIELD_MUL_ARRAY_ERR_EN is defined
//  Options  : FIELD_MUL_ARRAY_ERR_EN adds the err output.
//  Revision : 1.0 - initial release
// ============================================================================
module field_mul_array #(
    parameter int unsigned      NBITS  = 61,
    parameter logic [NBITS-1:0] PRIME  = 61'h1FFF_FFFF_FFFF_FFFF,
    parameter int unsigned      NLANES = 4
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     en,
    input  logic                     mac,
    input  logic [NLANES-1:0]        lane_mask,
    input  logic [NLANES*NBITS-1:0]  a,
    input  logic [NLANES*NBITS-1:0]  b,
    output logic                     ready_pulse,
    output logic                     ready,
    output logic [NLANES*NBITS-1:0]  c
`ifdef FIELD_MUL_ARRAY_ERR_EN
    ,
    output logic                     err
`endif
);

    localparam int unsigned      c_CW      = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [NBITS:0]   c_PRIME_X = {1'b0, PRIME};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ACC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CW-1:0]     r_cnt;
    logic                r_mac;
    logic [NLANES-1:0]   r_mask;
    logic                w_accept;
    logic                w_last;
    logic                w_load_c;

    // DONE doubles as an accepting state so back-to-back requests see no bubble.
    assign ready       = (r_state == S_IDLE) || (r_state == S_DONE);
    assign ready_pulse = (r_state == S_DONE);
    assign w_accept    = en && ready;
    assign w_last      = (r_cnt == '0);
    // Results are written on the edge that enters DONE, so c is already
    // valid during the ready_pulse cycle. Nothing is written earlier, so an
    // aborted operation never exposes a partial value.
    assign w_load_c    = ((r_state == S_RUN) && w_last && !r_mac) || (r_state == S_ACC);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (en) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = r_mac ? S_ACC : S_DONE;
            S_ACC:   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = en ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mac   <= 1'b0;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt  <= c_CW'(NBITS - 1);
                r_mac  <= mac;
                r_mask <= lane_mask;
            end else if ((r_state == S_RUN) && !w_last) begin
                r_cnt  <= r_cnt - 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
        logic [NBITS-1:0] r_a;
        logic [NBITS-1:0] r_b;      // shifted left each RUN cycle; MSB is the current bit
        logic [NBITS-1:0] r_acc;
        logic [NBITS-1:0] r_c;
        logic [NBITS-1:0] w_a_raw;
        logic [NBITS-1:0] w_b_raw;
        logic [NBITS-1:0] w_a_red;
        logic [NBITS-1:0] w_b_red;
        logic [NBITS:0]   w_dbl;
        logic [NBITS:0]   w_dbl_red;
        logic [NBITS:0]   w_add;
        logic [NBITS-1:0] w_step;
        logic [NBITS:0]   w_sum;
        logic [NBITS-1:0] w_macc;

        assign w_a_raw = a[gi*NBITS +: NBITS];
        assign w_b_raw = b[gi*NBITS +: NBITS];

        // PRIME > 2^(NBITS-1), so one conditional subtract fully reduces an input.
        assign w_a_red = ({1'b0, w_a_raw} >= c_PRIME_X) ? (w_a_raw - PRIME) : w_a_raw;
        assign w_b_red = ({1'b0, w_b_raw} >= c_PRIME_X) ? (w_b_raw - PRIME) : w_b_raw;

        // Interleaved step: acc = 2*acc (+ a) mod PRIME, every partial < 2*PRIME.
        assign w_dbl     = {r_acc, 1'b0};
        assign w_dbl_red = (w_dbl >= c_PRIME_X) ? (w_dbl - c_PRIME_X) : w_dbl;
        assign w_add     = r_b[NBITS-1] ? (w_dbl_red + {1'b0, r_a}) : w_dbl_red;
        assign w_step    = (w_add >= c_PRIME_X) ? NBITS'(w_add - c_PRIME_X) : NBITS'(w_add);

        // Accumulate with the previous result; both terms are already reduced.
        assign w_sum  = {1'b0, r_acc} + {1'b0, r_c};
        assign w_macc = (w_sum >= c_PRIME_X) ? NBITS'(w_sum - c_PRIME_X) : NBITS'(w_sum);

        always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
                r_a   <= '0;
                r_b   <= '0;
                r_acc <= '0;
                r_c   <= NBITS'(1);
            end else begin
                if (w_accept) begin
                    r_a   <= w_a_red;
                    r_b   <= w_b_red;
                    r_acc <= '0;
                end else if (r_state == S_RUN) begin
                    r_acc <= w_step;
                    r_b   <= r_b << 1;
                end else if (r_state == S_ACC) begin
                    r_acc <= w_macc;
                end
                if (w_load_c && r_mask[gi]) begin
                    r_c <= (r_state == S_ACC) ? w_macc : w_step;
                end
            end
        end

        assign c[gi*NBITS +: NBITS] = r_c;
    end

`ifdef FIELD_MUL_ARRAY_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_err <= 1'b0;
        end else if (en && !ready) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_field_mul_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_field_mul_array
//  Purpose  : Directed self-checking bench for field_mul_array with
//             NBITS=61, PRIME=2^61-1, NLANES=4 and hand-computed results.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_field_mul_array;

    localparam int          NB = 61;
    localparam int          NL = 4;
    localparam logic [60:0] P  = 61'h1FFF_FFFF_FFFF_FFFF;

    logic               clk;
    logic               rstb;
    logic               en;
    logic               mac;
    logic [NL-1:0]      lane_mask;
    logic [NL*NB-1:0]   a;
    logic [NL*NB-1:0]   b;
    logic               ready_pulse;
    logic               ready;
    logic [NL*NB-1:0]   c;
`ifdef FIELD_MUL_ARRAY_ERR_EN
    logic               err;
`endif

    logic [NL*NB-1:0]   a_v;
    logic [NL*NB-1:0]   b_v;
    int                 n_cmp;
    int                 n_bad;
    int                 n_cyc;
    int                 n_pulses;

    field_mul_array #(
        .NBITS  (NB),
        .PRIME  (P),
        .NLANES (NL)
    ) u_dut (
        .clk         (clk),
        .rstb        (rstb),
        .en          (en),
        .mac         (mac),
        .lane_mask   (lane_mask),
        .a           (a),
        .b           (b),
        .ready_pulse (ready_pulse),
        .ready       (ready),
        .c           (c)
`ifdef FIELD_MUL_ARRAY_ERR_EN
        ,
        .err         (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [60:0] lane(input int i);
        return c[i*NB +: NB];
    endfunction

    task automatic set_lane(input int i, input logic [60:0] av, input logic [60:0] bv);
        a_v[i*NB +: NB] = av;
        b_v[i*NB +: NB] = bv;
    endtask

    // Present a request on the next negedge and release en after the accepting edge.
    task automatic start_op(input logic m, input logic [NL-1:0] msk);
        @(negedge clk);
        mac       = m;
        lane_mask = msk;
        a         = a_v;
        b         = b_v;
        en        = 1'b1;
        @(posedge clk);
        #1;
        en        = 1'b0;
    endtask

    // Count rising edges (the accepting edge is 1) until ready_pulse is seen.
    task automatic wait_pulse(input int start, output int n);
        n = start;
        while (!ready_pulse && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rstb = 1'b0; en = 1'b0; mac = 1'b0; lane_mask = '0; a = '0; b = '0;
        a_v = '0; b_v = '0;
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        #1;

        // Reset state
        for (int i = 0; i < NL; i++) check($sformatf("rst_c%0d", i), lane(i), 1);
        check("rst_ready", ready, 1);
        check("rst_pulse", ready_pulse, 0);
`ifdef FIELD_MUL_ARRAY_ERR_EN
        check("rst_err", err, 0);
`endif

        // Basic multiply on all lanes
        set_lane(0, 3, 5);
        set_lane(1, P - 1, P - 1);
        set_lane(2, 61'h1000_0000_0000_0000, 2);
        set_lane(3, P, 7);
        start_op(1'b0, 4'b1111);
        check("mul_busy", ready, 0);
        wait_pulse(1, n_cyc);
        check("mul_latency", n_cyc, 62);
        check("mul_c0", lane(0), 15);
        check("mul_c1", lane(1), 1);
        check("mul_c2", lane(2), 1);
        check("mul_c3", lane(3), 0);
        check("mul_ready_at_pulse", ready, 1);
        @(posedge clk);
        #1;
        check("mul_pulse_width", ready_pulse, 0);

        // Multiply then multiply-accumulate on lanes 0 and 1
        set_lane(0, 3, 5);
        set_lane(1, P - 1, 1);
        set_lane(2, 99, 99);
        set_lane(3, 99, 99);
        start_op(1'b0, 4'b0011);
        wait_pulse(1, n_cyc);
        check("pre_mac_c0", lane(0), 15);
        check("pre_mac_c1", lane(1), P - 1);
        set_lane(0, 2, 3);
        set_lane(1, 1, 1);
        start_op(1'b1, 4'b0011);
        wait_pulse(1, n_cyc);
        check("mac_latency", n_cyc, 63);
        check("mac_c0", lane(0), 21);
        check("mac_c1_wrap", lane(1), 0);
        check("mac_c2_held", lane(2), 1);
        check("mac_c3_held", lane(3), 0);

        // Lane mask with back-to-back request in the ready_pulse cycle
        set_lane(0, 7, 11);
        set_lane(1, 9, 9);
        set_lane(2, 61'h1000_0000_0000_0000, 4);
        set_lane(3, 9, 9);
        start_op(1'b0, 4'b0101);
        wait_pulse(1, n_cyc);
        check("mask_latency", n_cyc, 62);
        check("mask_c0", lane(0), 77);
        check("mask_c1_held", lane(1), 0);
        check("mask_c2", lane(2), 2);
        check("mask_c3_held", lane(3), 0);
        set_lane(0, 5, 5);
        set_lane(1, P - 2, 3);
        set_lane(2, 5, 5);
        set_lane(3, 123456789, 1000);
        start_op(1'b0, 4'b1010);
        check("b2b_accepted", ready, 0);
        wait_pulse(1, n_cyc);
        check("b2b_latency", n_cyc, 62);
        check("b2b_c0_held", lane(0), 77);
        check("b2b_c1", lane(1), P - 6);
        check("b2b_c2_held", lane(2), 2);
        check("b2b_c3", lane(3), 64'd123456789000);

        // Request while busy is dropped
        set_lane(0, 5, 5);
        start_op(1'b0, 4'b0001);
        n_cyc = 1;
        repeat (9) begin
            @(posedge clk);
            #1;
            n_cyc++;
        end
        @(negedge clk);
        mac = 1'b1; lane_mask = 4'b1111; a = '1; b = '1; en = 1'b1;
        @(posedge clk);
        #1;
        n_cyc++;
        en = 1'b0;
        wait_pulse(n_cyc, n_cyc);
        check("busy_latency", n_cyc, 62);
        check("busy_c0", lane(0), 25);
        check("busy_c1_held", lane(1), P - 6);
        check("busy_c2_held", lane(2), 2);
        check("busy_c3_held", lane(3), 64'd123456789000);
`ifdef FIELD_MUL_ARRAY_ERR_EN
        check("busy_err", err, 1);
`endif
        @(posedge clk);
        #1;
        check("busy_no_second_op", ready, 1);

        // Reset in the middle of an operation
        set_lane(0, 3, 3);
        set_lane(1, 3, 3);
        set_lane(2, 3, 3);
        set_lane(3, 3, 3);
        start_op(1'b0, 4'b1111);
        repeat (29) @(posedge clk);
        @(negedge clk);
        rstb = 1'b0;
        #1;
        for (int i = 0; i < NL; i++) check($sformatf("abort_c%0d", i), lane(i), 1);
        check("abort_ready", ready, 1);
        check("abort_pulse", ready_pulse, 0);
        @(negedge clk);
        rstb = 1'b1;
        n_pulses = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (ready_pulse) n_pulses++;
        end
        check("abort_no_pulse", n_pulses, 0);
        check("abort_c0_after", lane(0), 1);
        check("abort_ready_after", ready, 1);
`ifdef FIELD_MUL_ARRAY_ERR_EN
        check("abort_err_cleared", err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
